control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/wb.
// Outputs are registered from the next-state decode.
module control_sequencer #(
  parameter int MEM_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      opcode,
  input  logic [5:0]      func,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      reg_write,
  output logic            imm_mux_ctrl,
  output logic            alu_mux_ctrl,
  output logic [3:0]      alu_op,
  output logic            dmem_enable,
  output logic            dmem_write_enable,
  output logic [1:0]      reg_write_mux_ctrl,
  output logic [4:0]      br_op,
  output logic            busy,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
  localparam logic [CNTW-1:0] ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state, nxt_state;
  logic [5:0]      op_q, fn_q, nxt_op, nxt_fn;
  logic [2:0]      cnt, nxt_cnt;
  logic            nxt_ill;
  logic [CNTW-1:0] nxt_ret;

  logic            d_ir, d_pc, d_amux, d_den, d_dwe, d_busy;
  logic [1:0]      d_rw, d_rwm;
  logic [3:0]      d_aop;
  logic [4:0]      d_br;

  // next state, latched instruction, mem counter, retire count
  always_comb begin
    nxt_state = state;
    nxt_op    = op_q;
    nxt_fn    = fn_q;
    nxt_cnt   = cnt;
    nxt_ill   = illegal;
    nxt_ret   = retired;
    unique case (state)
      S_IDLE:   if (start) nxt_state = S_FETCH;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        nxt_state = S_EXEC;
        nxt_op    = opcode;
        nxt_fn    = func;
      end
      S_EXEC: begin
        unique case (1'b1)
          (op_q <= 6'd1):        nxt_state = S_WB;
          (op_q[5:1] == 5'd1): begin
            nxt_state = S_MEM;
            nxt_cnt   = 3'd0;
          end
          (op_q == 6'd4): begin
            nxt_state = S_FETCH;
            nxt_ret   = retired + ONE;
          end
          (op_q == 6'd5):        nxt_state = S_HALT;
          default: begin
            nxt_state = S_HALT;
            nxt_ill   = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (cnt == LAST) begin
          if (op_q == 6'd3) begin
            nxt_state = S_FETCH;
            nxt_ret   = retired + ONE;
          end else begin
            nxt_state = S_WB;
          end
        end else begin
          nxt_cnt = cnt + 3'd1;
        end
      end
      S_WB: begin
        nxt_state = S_FETCH;
        nxt_ret   = retired + ONE;
      end
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // control outputs for the state being entered
  always_comb begin
    d_ir   = 1'b0;
    d_pc   = 1'b0;
    d_rw   = 2'b00;
    d_amux = 1'b0;
    d_aop  = 4'd0;
    d_den  = 1'b0;
    d_dwe  = 1'b0;
    d_rwm  = 2'b00;
    d_br   = 5'd0;
    d_busy = !(nxt_state == S_IDLE || nxt_state == S_HALT);
    if (nxt_op <= 6'd3 &&
        (nxt_state == S_EXEC || nxt_state == S_MEM ||
         nxt_state == S_WB)) begin
      d_amux = (nxt_op != 6'd0);
      d_aop  = (nxt_op == 6'd0) ? nxt_fn[3:0] : 4'd0;
    end
    unique case (nxt_state)
      S_FETCH: d_ir = 1'b1;
      S_EXEC: begin
        if (nxt_op == 6'd4) begin
          d_br = nxt_fn[4:0];
          d_pc = 1'b1;
        end
      end
      S_MEM: begin
        d_den = 1'b1;
        if (nxt_op == 6'd3) begin
          d_dwe = 1'b1;
          d_pc  = (nxt_cnt == LAST);
        end
      end
      S_WB: begin
        d_rw  = 2'b01;
        d_pc  = 1'b1;
        d_rwm = (nxt_op == 6'd2) ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_IDLE;
      op_q               <= '0;
      fn_q               <= '0;
      cnt                <= '0;
      illegal            <= 1'b0;
      retired            <= '0;
      ir_write           <= 1'b0;
      pc_write           <= 1'b0;
      reg_write          <= '0;
      imm_mux_ctrl       <= 1'b0;
      alu_mux_ctrl       <= 1'b0;
      alu_op             <= '0;
      dmem_enable        <= 1'b0;
      dmem_write_enable  <= 1'b0;
      reg_write_mux_ctrl <= '0;
      br_op              <= '0;
      busy               <= 1'b0;
    end else begin
      state              <= nxt_state;
      op_q               <= nxt_op;
      fn_q               <= nxt_fn;
      cnt                <= nxt_cnt;
      illegal            <= nxt_ill;
      retired            <= nxt_ret;
      ir_write           <= d_ir;
      pc_write           <= d_pc;
      reg_write          <= d_rw;
      imm_mux_ctrl       <= 1'b0;
      alu_mux_ctrl       <= d_amux;
      alu_op             <= d_aop;
      dmem_enable        <= d_den;
      dmem_write_enable  <= d_dwe;
      reg_write_mux_ctrl <= d_rwm;
      br_op              <= d_br;
      busy               <= d_busy;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer.
// Random programs against a per-instruction trace model.
module tb_control_sequencer;

  localparam int LAT = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    opcode = '0;
  logic [5:0]    func = '0;
  logic          ir_write, pc_write, imm_mux_ctrl;
  logic          alu_mux_ctrl, dmem_enable;
  logic          dmem_write_enable, busy, illegal;
  logic [1:0]    reg_write, reg_write_mux_ctrl;
  logic [3:0]    alu_op;
  logic [4:0]    br_op;
  logic [CW-1:0] retired;

  control_sequencer #(.MEM_LAT(LAT), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .opcode(opcode), .func(func),
    .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .imm_mux_ctrl(imm_mux_ctrl),
    .alu_mux_ctrl(alu_mux_ctrl), .alu_op(alu_op),
    .dmem_enable(dmem_enable),
    .dmem_write_enable(dmem_write_enable),
    .reg_write_mux_ctrl(reg_write_mux_ctrl),
    .br_op(br_op), .busy(busy), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int vec_n = 0;
  int err_n = 0;
  int r = 0;
  logic [24:0] exp_q[$];
  int          p_op[$];
  logic [5:0]  p_fn[$];

  function automatic logic [24:0] mk(
    logic ir, logic pc, logic [1:0] rw, logic amux,
    logic [3:0] aop, logic den, logic dwe,
    logic [1:0] rwm, logic [4:0] br, logic bsy,
    logic ill, logic [3:0] ret);
    return {ir, pc, rw, 1'b0, amux, aop, den, dwe,
            rwm, br, bsy, ill, ret};
  endfunction

  function automatic logic [24:0] act_v();
    return {ir_write, pc_write, reg_write, imm_mux_ctrl,
            alu_mux_ctrl, alu_op, dmem_enable,
            dmem_write_enable, reg_write_mux_ctrl, br_op,
            busy, illegal, retired};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(int op);
    if (op <= 1) return 4;
    if (op == 2) return 4 + LAT;
    if (op == 3) return 3 + LAT;
    return 3;
  endfunction

  // expected cycle trace of one instruction
  task automatic push_instr(int op, logic [5:0] fn);
    logic [3:0] aop, rr;
    logic       amux;
    rr   = 4'(r);
    aop  = (op == 0) ? fn[3:0] : 4'd0;
    amux = (op >= 1 && op <= 3);
    exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,rr));
    exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,rr));
    case (op)
      0, 1: begin
        exp_q.push_back(mk(0,0,0,amux,aop,0,0,0,0,1,0,rr));
        exp_q.push_back(mk(0,1,2'b01,amux,aop,0,0,2'b10,
                           0,1,0,rr));
        r++;
      end
      2: begin
        exp_q.push_back(mk(0,0,0,amux,aop,0,0,0,0,1,0,rr));
        for (int k = 0; k < LAT; k++)
          exp_q.push_back(mk(0,0,0,amux,aop,1,0,0,0,1,0,rr));
        exp_q.push_back(mk(0,1,2'b01,amux,aop,0,0,2'b01,
                           0,1,0,rr));
        r++;
      end
      3: begin
        exp_q.push_back(mk(0,0,0,amux,aop,0,0,0,0,1,0,rr));
        for (int k = 0; k < LAT; k++)
          exp_q.push_back(mk(0,(k == LAT-1),0,amux,aop,1,1,
                             0,0,1,0,rr));
        r++;
      end
      4: begin
        exp_q.push_back(mk(0,1,0,0,0,0,0,0,fn[4:0],1,0,rr));
        r++;
      end
      default:
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,rr));
    endcase
  endtask

  // monitor: every busy cycle pops one expected vector
  always @(negedge clk) begin
    if (rst && busy) begin
      if (exp_q.size() == 0) begin
        vec_n++;
        err_n++;
        $display("FAIL unexpected_busy got=%h t=%0t",
                 act_v(), $time);
      end else begin
        chk("cycle", {7'd0, act_v()},
            {7'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    start = 1'b0;
    #1 rst = 1'b0;
    #3 chk("reset", {7'd0, act_v()}, 32'd0);
    r = 0;
    exp_q.delete();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle", {7'd0, act_v()}, 32'd0);
  endtask

  task automatic run_prog();
    int last;
    logic ill;
    for (int i = 0; i < p_op.size(); i++)
      push_instr(p_op[i], p_fn[i]);
    last = p_op[p_op.size()-1];
    ill  = (last >= 6);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < p_op.size(); i++) begin
      for (int c = 0; c < lat_of(p_op[i]); c++) begin
        start = 1'($urandom);
        opcode = (c == 1) ? 6'(p_op[i]) : 6'($urandom);
        func   = (c == 1) ? p_fn[i] : 6'($urandom);
        @(posedge clk); #2;
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("halt", {7'd0, act_v()},
        {7'd0, mk(0,0,0,0,0,0,0,0,0,0,ill,4'(r))});
    chk("drained", exp_q.size(), 0);
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_start", {7'd0, act_v()},
        {7'd0, mk(0,0,0,0,0,0,0,0,0,0,ill,4'(r))});
  endtask

  task automatic add(int op, logic [5:0] fn);
    p_op.push_back(op);
    p_fn.push_back(fn);
  endtask

  initial begin
    do_reset();
    // R-type func 3, then halt
    p_op.delete(); p_fn.delete();
    add(0, 6'h03); add(5, 6'h00);
    run_prog();
    do_reset();
    // addi then lw
    p_op.delete(); p_fn.delete();
    add(1, 6'h11); add(2, 6'h2a); add(5, 6'h00);
    run_prog();
    do_reset();
    // branch
    p_op.delete(); p_fn.delete();
    add(4, 6'h01); add(0, 6'h07); add(5, 6'h00);
    run_prog();
    do_reset();
    // undefined opcode
    p_op.delete(); p_fn.delete();
    add(6'h3f, 6'h00);
    run_prog();
    do_reset();
    // 16 R-types wrap the 4-bit counter
    p_op.delete(); p_fn.delete();
    for (int i = 0; i < 16; i++) add(0, 6'(i));
    add(5, 6'h00);
    run_prog();
    do_reset();
    // reset between edges during sw MEM
    p_op.delete(); p_fn.delete();
    add(3, 6'h00); add(5, 6'h00);
    for (int i = 0; i < p_op.size(); i++)
      push_instr(p_op[i], p_fn[i]);
    opcode = 6'd3;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int k = 0; k < 20 && !dmem_write_enable; k++)
      @(negedge clk);
    chk("sw_mem_seen", {31'd0, dmem_write_enable}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("sw_reset_drop", {7'd0, act_v()}, 32'd0);
    exp_q.delete();
    r = 0;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("sw_reset_idle", {7'd0, act_v()}, 32'd0);
    // random programs
    for (int n = 0; n < 25; n++) begin
      do_reset();
      p_op.delete(); p_fn.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++)
        add($urandom_range(0, 4), 6'($urandom));
      if ($urandom_range(0, 1) == 1) add(5, 6'($urandom));
      else add($urandom_range(6, 63), 6'($urandom));
      run_prog();
    end
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, err_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
